// File: rtl/fetch_controller_pkg.sv
// Shared definitions for the IF-stage fetch controller: state encoding,
// PC step and the canonical NOP used by downstream flush logic.
package fetch_controller_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    localparam logic [31:0] PC_INC    = 32'd4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Sequential fetch address; wraps naturally at 2^32.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry output slot plus one-entry skid buffer feeding the IF/ID register.
// The slot is what decode sees; the skid catches the single access that can
// complete while decode is stalled.
module fetch_skid_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_flush,
    input  logic        i_push,
    input  logic [31:0] i_push_pc,
    input  logic [31:0] i_push_instr,
    input  logic        i_consume,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_instr,
    output logic        o_skid_valid
);

    logic        r_slot_valid;
    logic [31:0] r_slot_pc;
    logic [31:0] r_slot_instr;
    logic        r_skid_valid;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_instr;

    // Slot/skid update: flush wins, then refill the slot from skid or memory.
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values; data registers are reset too so out_pc/out_instr are
    // defined zeros after reset rather than X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_slot_valid <= 1'b0;
            r_slot_pc    <= '0;
            r_slot_instr <= '0;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= '0;
            r_skid_instr <= '0;
        end else if (i_flush) begin
            r_slot_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (i_consume || !r_slot_valid) begin
            // Slot is free at this edge: oldest instruction moves in first.
            if (r_skid_valid) begin
                r_slot_valid <= 1'b1;
                r_slot_pc    <= r_skid_pc;
                r_slot_instr <= r_skid_instr;
                r_skid_valid <= i_push;
                if (i_push) begin
                    r_skid_pc    <= i_push_pc;
                    r_skid_instr <= i_push_instr;
                end
            end else if (i_push) begin
                r_slot_valid <= 1'b1;
                r_slot_pc    <= i_push_pc;
                r_slot_instr <= i_push_instr;
            end else begin
                r_slot_valid <= 1'b0;
            end
        end else if (i_push) begin
            // Slot held by a stall: park the completing access in the skid.
            r_skid_valid <= 1'b1;
            r_skid_pc    <= i_push_pc;
            r_skid_instr <= i_push_instr;
        end
    end

    assign o_valid      = r_slot_valid;
    assign o_pc         = r_slot_pc;
    assign o_instr      = r_slot_instr;
    assign o_skid_valid = r_skid_valid;

endmodule

// File: rtl/fetch_controller.sv
// IF-stage sequencer: owns fetch_pc, runs the imem request/ready handshake,
// handles decode stalls and EX redirects (including redirects that land while
// an access is outstanding, which are resolved by draining that access).
module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned BOOT_DELAY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_sel_ex,
    input  logic [31:0] branch_target_ex,
    input  logic        hazard_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic [31:0] fetch_count
);

    localparam logic [8:0] BOOT_DELAY_W = 9'(BOOT_DELAY);

    fetch_state_e r_state;
    logic [7:0]   r_boot_cnt;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  r_pend_target;
    logic [31:0]  r_fetch_count;

    logic w_req;
    logic w_done;
    logic w_consume;
    logic w_push;
    logic w_skid_valid;
    logic w_boot_done;

    // Request is combinational from state so it drops the cycle the skid fills.
    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        w_req = 1'b0;
        case (r_state)
            ST_FETCH: w_req = !w_skid_valid;
            ST_DRAIN: w_req = 1'b1;
            default:  w_req = 1'b0;
        endcase
    end

    assign w_done      = w_req && imem_ready;
    // A redirect kills the slot contents, so nothing is consumed that cycle.
    assign w_consume   = out_valid && !hazard_stall && !pc_sel_ex;
    // Only right-path completions in FETCH deliver data; DRAIN data is dropped.
    assign w_push      = w_done && (r_state == ST_FETCH) && !pc_sel_ex;
    assign w_boot_done = ({1'b0, r_boot_cnt} + 9'd1) >= BOOT_DELAY_W;

    // Fetch FSM: boot delay, sequential fetch, and drain of a redirected access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_BOOT;
            r_boot_cnt    <= '0;
            r_fetch_pc    <= RESET_PC;
            r_pend_target <= '0;
            r_fetch_count <= '0;
        end else begin
            if (w_consume) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            case (r_state)
                ST_BOOT: begin
                    // Nothing outstanding yet: a redirect just retargets.
                    if (pc_sel_ex) begin
                        r_fetch_pc <= branch_target_ex;
                    end
                    if (w_boot_done) begin
                        r_state <= ST_FETCH;
                    end else begin
                        r_boot_cnt <= r_boot_cnt + 8'd1;
                    end
                end
                ST_FETCH: begin
                    if (pc_sel_ex) begin
                        if (w_req && !imem_ready) begin
                            // Access in flight must finish at its own address.
                            r_pend_target <= branch_target_ex;
                            r_state       <= ST_DRAIN;
                        end else begin
                            r_fetch_pc <= branch_target_ex;
                        end
                    end else if (w_done) begin
                        r_fetch_pc <= next_pc(r_fetch_pc);
                    end
                end
                ST_DRAIN: begin
                    if (pc_sel_ex) begin
                        // Latest redirect wins, even on the draining edge.
                        if (imem_ready) begin
                            r_fetch_pc <= branch_target_ex;
                            r_state    <= ST_FETCH;
                        end else begin
                            r_pend_target <= branch_target_ex;
                        end
                    end else if (imem_ready) begin
                        r_fetch_pc <= r_pend_target;
                        r_state    <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

    fetch_skid_buf u_skid_buf (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (pc_sel_ex),
        .i_push       (w_push),
        .i_push_pc    (r_fetch_pc),
        .i_push_instr (imem_instr),
        .i_consume    (w_consume),
        .o_valid      (out_valid),
        .o_pc         (out_pc),
        .o_instr      (out_instr),
        .o_skid_valid (w_skid_valid)
    );

    assign imem_req    = w_req;
    assign imem_addr   = r_fetch_pc;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller. The reference model is the
// instruction stream decode should see: consecutive word addresses from the
// last reset/redirect point, with data taken from a fixed memory function.
// A driver pushes that stream into a scoreboard queue; a monitor pops and
// compares on every consume, and checks handshake stability and fetch_count.
module tb_fetch_controller;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam int unsigned BOOT_DELAY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_sel_ex;
    logic [31:0] branch_target_ex;
    logic        hazard_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_instr;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] model_next;
    logic [31:0] model_count;

    always #5 clk = ~clk;

    // Memory contents: a fixed scramble of the address, never zero-pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    fetch_controller #(
        .RESET_PC   (RESET_PC),
        .BOOT_DELAY (BOOT_DELAY)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_sel_ex        (pc_sel_ex),
        .branch_target_ex (branch_target_ex),
        .hazard_stall     (hazard_stall),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_instr       (imem_instr),
        .out_valid        (out_valid),
        .out_pc           (out_pc),
        .out_instr        (out_instr),
        .fetch_count      (fetch_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, want, $time);
        end
    endtask

    // Keep the scoreboard stocked with the next expected instruction PCs.
    task automatic top_up();
        while (exp_q.size() < 8) begin
            exp_q.push_back(model_next);
            model_next = model_next + 32'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        top_up();
    endtask

    // Redirect restarts the expected stream at the target.
    task automatic redirect(input logic [31:0] t);
        pc_sel_ex        = 1'b1;
        branch_target_ex = t;
        exp_q.delete();
        model_next = t;
        top_up();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        exp_q.delete();
        model_next = RESET_PC;
        top_up();
    endtask

    task automatic wait_out(input logic [31:0] pc);
        int n = 0;
        while (!(out_valid && out_pc == pc) && n < 20) begin
            tick();
            n++;
        end
        if (n == 20) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_out: out_pc %h never presented, last %h", pc, out_pc);
        end
    endtask

    // Monitor: compare every consumed instruction against the scoreboard.
    initial begin
        logic        prev_pend;
        logic [31:0] prev_addr;
        logic [31:0] exp_pc;
        prev_pend   = 1'b0;
        prev_addr   = '0;
        model_count = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                model_count = '0;
                prev_pend   = 1'b0;
            end else begin
                check("fetch_count", fetch_count, model_count);
                if (prev_pend) begin
                    check1("req_held", imem_req, 1'b1);
                    check("addr_held", imem_addr, prev_addr);
                end
                if (out_valid && !hazard_stall && !pc_sel_ex) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL scoreboard: consume of pc %h with nothing expected", out_pc);
                    end else begin
                        exp_pc = exp_q.pop_front();
                        check("out_pc", out_pc, exp_pc);
                        check("out_instr", out_instr, mem_word(exp_pc));
                    end
                    model_count = model_count + 32'd1;
                end
                prev_pend = imem_req && !imem_ready;
                prev_addr = imem_addr;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    // Driver: directed scenarios, then randomized traffic.
    initial begin
        logic [31:0] t;
        pc_sel_ex        = 1'b0;
        branch_target_ex = '0;
        hazard_stall     = 1'b0;
        imem_ready       = 1'b0;
        model_next       = RESET_PC;
        apply_reset();
        repeat (3) @(posedge clk);
        #1;
        check1("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, RESET_PC);
        check1("rst_valid", out_valid, 1'b0);
        check("rst_pc", out_pc, 32'h0);
        check("rst_instr", out_instr, 32'h0);
        check("rst_count", fetch_count, 32'h0);

        // Boot: two idle cycles, then back-to-back fetch from RESET_PC.
        imem_ready = 1'b1;
        rst        = 1'b0;
        tick();
        check1("boot_idle", imem_req, 1'b0);
        tick();
        check1("boot_req", imem_req, 1'b1);
        check("boot_addr", imem_addr, RESET_PC);
        for (int i = 0; i < 3; i++) begin
            tick();
            check1("boot_valid", out_valid, 1'b1);
            check("boot_stream", out_pc, 32'(i * 4));
        end

        // Stall: slot keeps 0x10, skid takes 0x14, request drops.
        wait_out(32'h10);
        hazard_stall = 1'b1;
        repeat (5) tick();
        check("stall_slot", out_pc, 32'h10);
        check1("stall_req", imem_req, 1'b0);
        check("stall_addr", imem_addr, 32'h18);
        hazard_stall = 1'b0;
        tick();
        check("unstall_a", out_pc, 32'h14);
        tick();
        check("unstall_b", out_pc, 32'h18);

        // Redirect while idle (skid full, no request) at fetch_pc 0x20.
        hazard_stall = 1'b1;
        tick();
        check("idle_addr", imem_addr, 32'h20);
        check1("idle_req", imem_req, 1'b0);
        redirect(32'h100);
        tick();
        pc_sel_ex    = 1'b0;
        hazard_stall = 1'b0;
        check1("redir_valid", out_valid, 1'b0);
        check("redir_addr", imem_addr, 32'h100);
        check1("redir_req", imem_req, 1'b1);

        // Redirect on the completing edge: the 0x100 data is dropped.
        redirect(32'h40);
        tick();
        pc_sel_ex  = 1'b0;
        imem_ready = 1'b0;
        check1("same_edge_drop", out_valid, 1'b0);
        check("same_edge_addr", imem_addr, 32'h40);

        // Redirects while 0x40 is outstanding; last one (0x300) wins.
        tick();
        redirect(32'h200);
        tick();
        check("drain_hold_a", imem_addr, 32'h40);
        redirect(32'h300);
        tick();
        pc_sel_ex  = 1'b0;
        check("drain_hold_b", imem_addr, 32'h40);
        imem_ready = 1'b1;
        tick();
        check("drain_target", imem_addr, 32'h300);
        check1("drain_drop", out_valid, 1'b0);
        tick();
        check1("drain_next_valid", out_valid, 1'b1);
        check("drain_next_pc", out_pc, 32'h300);

        // Slow memory: ready every third cycle.
        for (int i = 0; i < 30; i++) begin
            imem_ready = (i % 3 == 2);
            tick();
        end

        // Reset mid-access, then a redirect during BOOT.
        imem_ready = 1'b0;
        tick();
        #3;
        apply_reset();
        #1;
        check1("midrst_req", imem_req, 1'b0);
        check("midrst_addr", imem_addr, RESET_PC);
        check1("midrst_valid", out_valid, 1'b0);
        check("midrst_count", fetch_count, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        redirect(32'h500);
        imem_ready = 1'b1;
        tick();
        pc_sel_ex = 1'b0;
        check1("boot_redir_req", imem_req, 1'b0);
        check("boot_redir_addr", imem_addr, 32'h500);
        tick();
        check1("boot_redir_start", imem_req, 1'b1);
        check("boot_redir_addr2", imem_addr, 32'h500);

        // Randomized traffic, including redirects that wrap past 2^32.
        for (int i = 0; i < 3000; i++) begin
            imem_ready   = ($urandom_range(0, 99) < 60);
            hazard_stall = ($urandom_range(0, 99) < 30);
            if ($urandom_range(0, 99) < 4) begin
                if ($urandom_range(0, 9) == 0) begin
                    t = 32'hFFFF_FFF8;
                end else begin
                    t = {18'h0, 12'($urandom), 2'b00};
                end
                redirect(t);
            end else begin
                pc_sel_ex = 1'b0;
            end
            tick();
        end
        pc_sel_ex    = 1'b0;
        hazard_stall = 1'b0;
        imem_ready   = 1'b1;
        repeat (5) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
